// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA-style raster timing generator with clock-enable pixel strobe
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CLK_DIV   = 4,
    parameter int CW        = 10,
    parameter int FCW       = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    output logic           pix_ce,
    output logic [CW-1:0]  hpos,
    output logic [CW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count,
    output logic           running
);

    // Last pixel column / last line of the full raster (visible + blanking).
    localparam int H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;

    // Divider needs at least one bit even when every clk is a pixel.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Refuse to build with a zero divider or a raster that overflows the counters.
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (longint'(H_MAX) >= (longint'(1) << CW)) begin : g_bad_h_max
        $error("vga_timing_gen: H_MAX does not fit in CW bits");
    end
    if (longint'(V_MAX) >= (longint'(1) << CW)) begin : g_bad_v_max
        $error("vga_timing_gen: V_MAX does not fit in CW bits");
    end

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_MAX_C   = CW'(H_MAX);
    localparam logic [CW-1:0] V_MAX_C   = CW'(V_MAX);
    localparam logic [CW-1:0] H_DISP_C  = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP_C  = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST  = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic          H_ACT_LVL = (H_POL != 0);
    localparam logic          V_ACT_LVL = (V_POL != 0);

    // DRAIN keeps scanning after enable drops so the current frame always completes.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_div;
    logic [CW-1:0]  r_hpos;
    logic [CW-1:0]  r_vpos;
    logic [FCW-1:0] r_fcnt;

    logic w_running;
    logic w_pix_ce;
    logic w_h_last;
    logic w_v_last;
    logic w_eof;
    logic w_h_vis;
    logic w_v_vis;
    logic w_hs_act;
    logic w_vs_act;

    // Everything below is decoded from registers only, so enable never reaches the outputs combinationally.
    assign w_running = (r_state != S_IDLE);
    assign w_pix_ce  = w_running && (r_div == DIV_LAST);
    assign w_h_last  = (r_hpos == H_MAX_C);
    assign w_v_last  = (r_vpos == V_MAX_C);
    assign w_eof     = w_pix_ce && w_h_last && w_v_last;
    assign w_h_vis   = (r_hpos < H_DISP_C);
    assign w_v_vis   = (r_vpos < V_DISP_C);
    assign w_hs_act  = (r_hpos >= HS_FIRST) && (r_hpos <= HS_LAST);
    assign w_vs_act  = (r_vpos >= VS_FIRST) && (r_vpos <= VS_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: re-enabling during DRAIN resumes seamlessly without restarting the frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enable) begin
                    w_state_nxt = S_RUN;
                end else if (w_eof) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel divider: free-runs 0..CLK_DIV-1 while scanning, parked at 0 when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!w_running || w_pix_ce) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Raster position: advances one pixel per strobe; the end-of-frame wrap leaves (0,0) for the next run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (!w_running) begin
            r_hpos <= '0;
            r_vpos <= '0;
        end else if (w_pix_ce) begin
            if (w_h_last) begin
                r_hpos <= '0;
                r_vpos <= w_v_last ? '0 : r_vpos + CW'(1);
            end else begin
                r_hpos <= r_hpos + CW'(1);
            end
        end
    end

    // Completed-frame counter; survives trips through IDLE and only clears on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fcnt <= '0;
        end else if (w_eof) begin
            r_fcnt <= r_fcnt + FCW'(1);
        end
    end

    assign running     = w_running;
    assign pix_ce      = w_pix_ce;
    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign hsync       = (w_running && w_hs_act) ? H_ACT_LVL : ~H_ACT_LVL;
    assign vsync       = (w_running && w_vs_act) ? V_ACT_LVL : ~V_ACT_LVL;
    assign display_on  = w_running && w_h_vis && w_v_vis;
    assign line_start  = w_pix_ce && (r_hpos == '0);
    assign frame_start = w_pix_ce && (r_hpos == '0) && (r_vpos == '0);
    assign frame_count = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int CW  = 10;
    localparam int FCW = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;

    logic           pix_ce0, hsync0, vsync0, disp0, ls0, fs0, run0;
    logic [CW-1:0]  hpos0, vpos0;
    logic [FCW-1:0] fc0;
    logic           pix_ce1, hsync1, vsync1, disp1, ls1, fs1, run1;
    logic [CW-1:0]  hpos1, vpos1;
    logic [FCW-1:0] fc1;

    int n_vec = 0;
    int n_bad = 0;

    // Active-low sync instance.
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(2), .CW(CW), .FCW(FCW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_ce(pix_ce0), .hpos(hpos0), .vpos(vpos0),
        .hsync(hsync0), .vsync(vsync0), .display_on(disp0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0),
        .running(run0)
    );

    // Active-high sync instance sharing the same stimulus.
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(2), .CW(CW), .FCW(FCW)
    ) dut_p (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_ce(pix_ce1), .hpos(hpos1), .vpos(vpos1),
        .hsync(hsync1), .vsync(vsync1), .display_on(disp1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1),
        .running(run1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Expected outputs k clks into an uninterrupted scan: 2 clk/pixel, 14 pixels/line, 7 lines/frame.
    task automatic chk_run(input int k, input int fcb);
        int p, h, v, pc, hs, vs, dsp;
        p   = k / 2;
        h   = p % 14;
        v   = (p / 14) % 7;
        pc  = k % 2;
        hs  = (h == 10 || h == 11) ? 1 : 0;
        vs  = (v == 5) ? 1 : 0;
        dsp = (h < 8 && v < 4) ? 1 : 0;
        chk("running",     k, 32'(run0),    32'(1));
        chk("running_p",   k, 32'(run1),    32'(1));
        chk("pix_ce",      k, 32'(pix_ce0), 32'(pc));
        chk("hpos",        k, 32'(hpos0),   32'(h));
        chk("vpos",        k, 32'(vpos0),   32'(v));
        chk("hsync",       k, 32'(hsync0),  32'(1 - hs));
        chk("vsync",       k, 32'(vsync0),  32'(1 - vs));
        chk("hsync_p",     k, 32'(hsync1),  32'(hs));
        chk("vsync_p",     k, 32'(vsync1),  32'(vs));
        chk("display_on",  k, 32'(disp0),   32'(dsp));
        chk("line_start",  k, 32'(ls0),     32'((pc == 1 && h == 0) ? 1 : 0));
        chk("frame_start", k, 32'(fs0),     32'((pc == 1 && h == 0 && v == 0) ? 1 : 0));
        chk("frame_count", k, 32'(fc0),     32'(fcb + k / 196));
    endtask

    // Expected outputs while idle or held in reset.
    task automatic chk_idle(input int k, input int fc);
        chk("idle_running",     k, 32'(run0),    32'(0));
        chk("idle_running_p",   k, 32'(run1),    32'(0));
        chk("idle_pix_ce",      k, 32'(pix_ce0), 32'(0));
        chk("idle_hpos",        k, 32'(hpos0),   32'(0));
        chk("idle_vpos",        k, 32'(vpos0),   32'(0));
        chk("idle_hsync",       k, 32'(hsync0),  32'(1));
        chk("idle_vsync",       k, 32'(vsync0),  32'(1));
        chk("idle_hsync_p",     k, 32'(hsync1),  32'(0));
        chk("idle_vsync_p",     k, 32'(vsync1),  32'(0));
        chk("idle_display_on",  k, 32'(disp0),   32'(0));
        chk("idle_line_start",  k, 32'(ls0),     32'(0));
        chk("idle_frame_start", k, 32'(fs0),     32'(0));
        chk("idle_frame_count", k, 32'(fc0),     32'(fc));
    endtask

    task automatic run_span(input int k0, input int k1, input int fcb);
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            chk_run(k, fcb);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;

        // Reset values, including with enable requested during reset.
        repeat (3) @(negedge clk);
        chk_idle(-1, 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle(-1, 0);

        // Released from reset with enable low: must stay idle.
        enable  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle(-10 - i, 0);
        end

        // Continuous run for three frames.
        enable = 1'b1;
        run_span(0, 588, 0);
        chk("fc_after_588", 588, 32'(fc0), 32'(3));
        chk("fc_after_588_p", 588, 32'(fc1), 32'(3));

        // Drop enable at (3,2) of frame 3; frame must drain to (13,6) then go idle.
        run_span(589, 650, 0);
        enable = 1'b0;
        run_span(651, 783, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle(784 + i, 4);
        end

        // Restart; drop at line 1, re-raise at line 3: scan must continue untouched.
        enable = 1'b1;
        run_span(0, 28, 4);
        enable = 1'b0;
        run_span(29, 84, 4);
        enable = 1'b1;
        run_span(85, 290, 4);

        // Asynchronous reset at (5,3): outputs drop before any clock edge.
        reset_n = 1'b0;
        #1;
        chk_idle(-100, 0);
        @(negedge clk);
        chk_idle(-101, 0);
        reset_n = 1'b1;
        run_span(0, 30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CLK_DIV, 4, clk cycles per pixel (at least 1)
- CW, 10, hpos/vpos width
- FCW, 16, frame_count width
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge
- reset_n, in, 1, asynchronous active-low reset
- enable, in, 1, level request to generate timing
- pix_ce, out, 1, pixel clock-enable strobe
- hpos, out, CW, current pixel column
- vpos, out, CW, current line
- hsync, out, 1, horizontal sync at H_POL when active
- vsync, out, 1, vertical sync at V_POL when active
- display_on, out, 1, current pixel is in the visible area
- line_start, out, 1, one-clk pulse on the first pixel of each line
- frame_start, out, 1, one-clk pulse on the first pixel of each frame
- frame_count, out, FCW, count of completed frames
- running, out, 1, high in states RUN or DRAIN
REQ-003 The block SHALL use one clock; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 H_MAX SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1.
REQ-005 V_MAX SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK-1.
REQ-006 Elaboration SHALL fail if CLK_DIV<1, or if H_MAX or V_MAX does not fit in CW bits.
REQ-007 The state machine SHALL have three states:
- IDLE, with transition to RUN on the first clk where enable=1.
- RUN, with transition to DRAIN when enable=0.
- DRAIN, with transition back to RUN when enable=1, or to IDLE at the end-of-frame pixel.
REQ-008 The end-of-frame pixel SHALL be the clk where pix_ce=1, hpos=H_MAX and vpos=V_MAX.
REQ-009 The divider SHALL count 0..CLK_DIV-1 only while running, and SHALL be held at 0 in IDLE.
REQ-010 pix_ce SHALL be 1 only while running, and only when the divider equals CLK_DIV-1.
REQ-011 With CLK_DIV=1, pix_ce SHALL be 1 on every running clk.
REQ-012 hpos and vpos SHALL change only at the end of a clk where pix_ce=1.
REQ-013 On that clk, hpos SHALL wrap from H_MAX to 0, or else increment.
REQ-014 vpos SHALL increment only when hpos wraps, and SHALL wrap from V_MAX to 0.
REQ-015 hsync SHALL equal H_POL when running and hpos is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; otherwise it SHALL equal ~H_POL.
REQ-016 vsync SHALL equal V_POL when running and vpos is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]; otherwise it SHALL equal ~V_POL.
REQ-017 display_on SHALL be 1 only when running, hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-018 hsync, vsync and display_on SHALL have zero skew relative to the hpos/vpos values presented on the same clk.
REQ-019 hsync, vsync and display_on SHALL be decoded from registered state only, with no combinational path from enable.
REQ-020 line_start SHALL equal pix_ce AND hpos==0.
REQ-021 frame_start SHALL equal pix_ce AND hpos==0 AND vpos==0.
REQ-022 frame_count SHALL increment modulo 2^FCW on every end-of-frame pixel, and SHALL NOT be cleared on entering IDLE.
REQ-023 On entering IDLE, hpos, vpos and the divider SHALL be 0, so the next RUN starts at pixel (0,0).
REQ-024 When enable drops and rises again within one frame, timing SHALL continue without disturbance and no new frame_start SHALL occur.

Reset
REQ-025 While reset_n=0, the state SHALL be IDLE.
REQ-026 While reset_n=0, hpos, vpos, the divider and frame_count SHALL be 0.
REQ-027 While reset_n=0, pix_ce, display_on, line_start, frame_start and running SHALL be 0.
REQ-028 While reset_n=0, hsync SHALL be ~H_POL and vsync SHALL be ~V_POL.
REQ-029 Asserting reset_n mid-frame SHALL take effect immediately, with no completion of the frame.
REQ-030 After reset_n rises, the block SHALL remain in IDLE until enable=1.

Verification
Bench parameters: H_DISPLAY/H_FRONT/H_SYNC/H_BACK = 8/2/2/2 (H_MAX=13), V_DISPLAY/V_FRONT/V_SYNC/V_BACK = 4/1/1/1 (V_MAX=6), CLK_DIV=2.
REQ-031 Scenario: reset, then hold enable=1. Required response:
- pix_ce on every 2nd clk.
- line period 28 clk and frame period 196 clk.
- frame_count = 3 after 588 clk.
REQ-032 Scenario: sync check. Required response:
- hsync low exactly for hpos 10..11, and high in IDLE.
- vsync low exactly for vpos 5.
- display_on exactly for hpos<8 and vpos<4.
REQ-033 Scenario: H_POL=1, V_POL=1. Required response:
- hsync and vsync inverted.
- idle level of both = 0.
REQ-034 Scenario: drop enable at hpos=3, vpos=2. Required response:
- running stays 1 through the end-of-frame pixel (13,6).
- then IDLE with hpos=0, vpos=0 and frame_count incremented once.
REQ-035 Scenario: drop enable at vpos=1, re-raise at vpos=3. Required response:
- no break in pix_ce, hpos or vpos.
- frame_start only at (0,0).
REQ-036 Scenario: reset_n pulse low at hpos=5, vpos=3. Required response:
- all outputs at reset values asynchronously.
- with enable=1 held, restart at (0,0) and frame_start on the first pix_ce.
